// File: rtl/dec10b8b_pkg.sv
// rtl/dec10b8b_pkg.sv - half-code tables and shared types for the 10b/8b receive decoder
package dec10b8b_pkg;

  typedef enum logic [2:0] {CLS_H1, CLS_H2, CLS_H3, CLS_H4, CLS_BAD} half_cls_e;
  typedef logic [3:0] half_idx_t;

  typedef struct packed {
    half_cls_e cls;
    half_idx_t idx;
  } half_dec_t;

  typedef enum logic [1:0] {WK_DATA, WK_CTRL, WK_IDLE, WK_ERR} word_kind_e;
  typedef enum logic {ST_HUNT, ST_SYNC} sync_state_e;

  localparam logic [4:0] H3_CODES [10] = '{5'b00111, 5'b01011, 5'b01101, 5'b01110, 5'b10011,
                                           5'b10101, 5'b10110, 5'b11001, 5'b11010, 5'b11100};
  localparam logic [4:0] H2_CODES [10] = '{5'b00011, 5'b00101, 5'b00110, 5'b01010, 5'b01100,
                                           5'b01001, 5'b10001, 5'b10010, 5'b10100, 5'b11000};
  localparam logic [4:0] H4_CODES [5]  = '{5'b11110, 5'b11101, 5'b11011, 5'b10111, 5'b01111};
  localparam logic [4:0] H1_CODES [5]  = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000};

  localparam logic [9:0] IDLE_CODE = 10'h29A;

endpackage

// File: rtl/dec10b8b_rx_half5_decode.sv
// rtl/dec10b8b_rx_half5_decode.sv - classify one 5-bit half into {class, table index}
module half5_decode
  import dec10b8b_pkg::*;
(
  input  logic [4:0] half_i,
  output half_dec_t  dec_o
);

  always_comb begin
    dec_o = '{cls: CLS_BAD, idx: '0};
    for (int i = 0; i < 10; i++) begin
      if (half_i == H3_CODES[i]) dec_o = '{cls: CLS_H3, idx: half_idx_t'(i)};
      if (half_i == H2_CODES[i]) dec_o = '{cls: CLS_H2, idx: half_idx_t'(i)};
    end
    for (int i = 0; i < 5; i++) begin
      if (half_i == H4_CODES[i]) dec_o = '{cls: CLS_H4, idx: half_idx_t'(i)};
      if (half_i == H1_CODES[i]) dec_o = '{cls: CLS_H1, idx: half_idx_t'(i)};
    end
  end

endmodule

// File: rtl/dec10b8b_rx.sv
// rtl/dec10b8b_rx.sv - two-stage 10b/8b receive decoder with sync hysteresis and error count
module dec10b8b_rx
  import dec10b8b_pkg::*;
#(
  parameter int SYNC_GOOD = 4,
  parameter int LOSS_BAD  = 3,
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic                 in_valid_i,
  input  logic [9:0]           in10b_i,
  input  logic                 clr_cnt_i,
  output logic                 out_stb_o,
  output logic [7:0]           data_o,
  output logic                 is_data_o,
  output logic                 idle_o,
  output logic                 code_err_o,
  output logic                 sync_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  localparam int GW = $clog2(SYNC_GOOD + 1);
  localparam int BW = $clog2(LOSS_BAD + 1);

  half_dec_t msb_dec, lsb_dec, s1_msb_q, s1_lsb_q;
  logic      s1_valid_q;
  half_idx_t mi, li;

  half5_decode u_msb (.half_i(in10b_i[9:5]), .dec_o(msb_dec));
  half5_decode u_lsb (.half_i(in10b_i[4:0]), .dec_o(lsb_dec));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_msb_q   <= '{cls: CLS_BAD, idx: '0};
      s1_lsb_q   <= '{cls: CLS_BAD, idx: '0};
    end else begin
      s1_valid_q <= in_valid_i & enable_i;
      s1_msb_q   <= msb_dec;
      s1_lsb_q   <= lsb_dec;
    end
  end

  assign mi = s1_msb_q.idx;
  assign li = s1_lsb_q.idx;

  // Indices 8/9 of the 10-entry tables are the ones with idx[3] set; H4/H1 index 4 has idx[2] set.
  word_kind_e kind_d;
  logic [7:0] byte_d;
  always_comb begin
    kind_d = WK_ERR;
    byte_d = 8'h00;
    if (s1_msb_q.cls == CLS_H3 && s1_lsb_q.cls == CLS_H2) begin
      kind_d = WK_DATA;
      case ({mi[3], li[3]})
        2'b00:   byte_d = {2'b00, mi[2:0], li[2:0]};
        2'b10:   byte_d = {4'b1000, mi[0], li[2:0]};
        2'b01:   byte_d = {4'b1010, li[0], mi[2:0]};
        default: byte_d = {6'b111100, mi[0], li[0]};
      endcase
    end else if (s1_msb_q.cls == CLS_H2 && s1_lsb_q.cls == CLS_H3) begin
      kind_d = WK_DATA;
      case ({mi[3], li[3]})
        2'b00:   byte_d = {2'b01, mi[2:0], li[2:0]};
        2'b10:   byte_d = {4'b1001, mi[0], li[2:0]};
        2'b01:   byte_d = {4'b1011, li[0], mi[2:0]};
        default: begin
          if (mi[0])      byte_d = {7'b1111010, li[0]};
          else if (!li[0]) kind_d = WK_IDLE;
          else            kind_d = WK_ERR;
        end
      endcase
    end else if (s1_msb_q.cls == CLS_H4 && s1_lsb_q.cls == CLS_H1) begin
      kind_d = WK_DATA;
      case ({mi[2], li[2]})
        2'b00:   byte_d = {4'b1100, mi[1:0], li[1:0]};
        2'b10:   byte_d = {6'b111000, li[1:0]};
        2'b01:   byte_d = {6'b111010, mi[1:0]};
        default: byte_d = 8'hF6;
      endcase
    end else if (s1_msb_q.cls == CLS_H1 && s1_lsb_q.cls == CLS_H4) begin
      kind_d = WK_DATA;
      case ({mi[2], li[2]})
        2'b00:   byte_d = {4'b1101, mi[1:0], li[1:0]};
        2'b10:   byte_d = {6'b111001, li[1:0]};
        2'b01:   byte_d = {6'b111011, mi[1:0]};
        default: byte_d = 8'hF7;
      endcase
    end else if (s1_msb_q.cls == CLS_H3 && s1_lsb_q.cls == CLS_H3) begin
      if (!mi[3] && !li[3]) begin
        kind_d = WK_CTRL;
        byte_d = {2'b00, mi[2:0], li[2:0]};
      end else if (mi == 4'd8 && !li[3]) begin
        kind_d = WK_DATA;
        byte_d = {5'b11111, li[2:0]};
      end
    end
  end

  logic out_stb_q, idle_q, code_err_q, is_data_q, err_now;
  logic [7:0] data_q;
  assign err_now = s1_valid_q && kind_d == WK_ERR;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_stb_q  <= 1'b0;
      idle_q     <= 1'b0;
      code_err_q <= 1'b0;
      data_q     <= 8'h00;
      is_data_q  <= 1'b0;
    end else begin
      out_stb_q  <= s1_valid_q && (kind_d == WK_DATA || kind_d == WK_CTRL);
      idle_q     <= s1_valid_q && kind_d == WK_IDLE;
      code_err_q <= err_now;
      if (s1_valid_q && kind_d != WK_IDLE) begin
        data_q    <= byte_d;
        is_data_q <= (kind_d == WK_DATA);
      end
    end
  end

  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (clr_cnt_i)                       err_cnt_d = err_now ? ERR_CNT_W'(1) : '0;
    else if (err_now && err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
  end

  // Sync hysteresis runs on the registered pulses, so sync_o trails the deciding word by a cycle.
  sync_state_e   state_q, state_d;
  logic [GW-1:0] good_cnt_q, good_cnt_d;
  logic [BW-1:0] bad_cnt_q, bad_cnt_d;
  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    if (out_stb_q || idle_q) begin
      bad_cnt_d = '0;
      if (good_cnt_q != GW'(SYNC_GOOD)) good_cnt_d = good_cnt_q + 1'b1;
      if (state_q == ST_HUNT && good_cnt_d == GW'(SYNC_GOOD)) state_d = ST_SYNC;
    end else if (code_err_q) begin
      good_cnt_d = '0;
      if (bad_cnt_q != BW'(LOSS_BAD)) bad_cnt_d = bad_cnt_q + 1'b1;
      if (state_q == ST_SYNC && bad_cnt_d == BW'(LOSS_BAD)) state_d = ST_HUNT;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_HUNT;
      good_cnt_q <= '0;
      bad_cnt_q  <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      good_cnt_q <= good_cnt_d;
      bad_cnt_q  <= bad_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign out_stb_o  = out_stb_q;
  assign data_o     = data_q;
  assign is_data_o  = is_data_q;
  assign idle_o     = idle_q;
  assign code_err_o = code_err_q;
  assign sync_o     = (state_q == ST_SYNC);
  assign err_cnt_o  = err_cnt_q;

endmodule

// File: tb/tb_dec10b8b_rx.sv
// tb/tb_dec10b8b_rx.sv - directed bench for dec10b8b_rx against an encode-table reference model
module tb_dec10b8b_rx;

  localparam int SYNC_GOOD = 4;
  localparam int LOSS_BAD  = 3;

  localparam logic [4:0] T_H3 [10] = '{5'b00111, 5'b01011, 5'b01101, 5'b01110, 5'b10011,
                                       5'b10101, 5'b10110, 5'b11001, 5'b11010, 5'b11100};
  localparam logic [4:0] T_H2 [10] = '{5'b00011, 5'b00101, 5'b00110, 5'b01010, 5'b01100,
                                       5'b01001, 5'b10001, 5'b10010, 5'b10100, 5'b11000};
  localparam logic [4:0] T_H4 [5]  = '{5'b11110, 5'b11101, 5'b11011, 5'b10111, 5'b01111};
  localparam logic [4:0] T_H1 [5]  = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic vld = 1'b0;
  logic clr = 1'b0;
  logic [9:0] code = '0;

  logic a_stb, a_isd, a_idle, a_err, a_sync;
  logic [7:0] a_data;
  logic [15:0] a_cnt;
  logic b_stb, b_isd, b_idle, b_err, b_sync;
  logic [7:0] b_data;
  logic [1:0] b_cnt;

  always #5 clk = ~clk;

  dec10b8b_rx #(.SYNC_GOOD(SYNC_GOOD), .LOSS_BAD(LOSS_BAD), .ERR_CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .in_valid_i(vld), .in10b_i(code), .clr_cnt_i(clr),
    .out_stb_o(a_stb), .data_o(a_data), .is_data_o(a_isd), .idle_o(a_idle),
    .code_err_o(a_err), .sync_o(a_sync), .err_cnt_o(a_cnt));

  dec10b8b_rx #(.SYNC_GOOD(SYNC_GOOD), .LOSS_BAD(LOSS_BAD), .ERR_CNT_W(2)) dut_w2 (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .in_valid_i(vld), .in10b_i(code), .clr_cnt_i(clr),
    .out_stb_o(b_stb), .data_o(b_data), .is_data_o(b_isd), .idle_o(b_idle),
    .code_err_o(b_err), .sync_o(b_sync), .err_cnt_o(b_cnt));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Forward encoder written straight from the byte map; the decoder must be its inverse.
  function automatic logic [9:0] enc(input logic [7:0] b, input bit is_data);
    logic [9:0] r;
    logic [2:0] f;
    logic [1:0] e, g;
    f = b[2:0];
    e = b[3:2];
    g = b[1:0];
    r = '0;
    if (!is_data) r = {T_H3[b[5:3]], T_H3[f]};
    else case (b[7:6])
      2'd0: r = {T_H3[b[5:3]], T_H2[f]};
      2'd1: r = {T_H2[b[5:3]], T_H3[f]};
      2'd2: case (b[5:4])
        2'd0: r = {T_H3[8 + b[3]], T_H2[f]};
        2'd1: r = {T_H2[8 + b[3]], T_H3[f]};
        2'd2: r = {T_H3[f], T_H2[8 + b[3]]};
        default: r = {T_H2[f], T_H3[8 + b[3]]};
      endcase
      default: case (b[5:4])
        2'd0: r = {T_H4[e], T_H1[g]};
        2'd1: r = {T_H1[e], T_H4[g]};
        2'd2: case (b[3:2])
          2'd0: r = {T_H4[4], T_H1[g]};
          2'd1: r = {T_H1[4], T_H4[g]};
          2'd2: r = {T_H4[g], T_H1[4]};
          default: r = {T_H1[g], T_H4[4]};
        endcase
        default: begin
          if (b[3])       r = {T_H3[8], T_H3[f]};
          else if (!b[2]) r = {T_H3[8 + b[1]], T_H2[8 + b[0]]};
          else if (!b[1]) r = {T_H2[9], T_H3[8 + b[0]]};
          else if (b[0])  r = {T_H1[4], T_H4[4]};
          else            r = {T_H4[4], T_H1[4]};
        end
      endcase
    endcase
    return r;
  endfunction

  // code -> kind (1 data, 2 control, 3 idle); absent keys are code errors
  int         code_kind [int];
  logic [7:0] code_byte [int];

  bit         m_s1_v;
  logic [9:0] m_s1_code;
  bit         e_stb, e_idle, e_err, e_isd, e_sync;
  logic [7:0] e_data;
  int         e_cnt16, e_cnt2, m_good, m_bad;
  int         stb_count, idle_count, err_count;
  logic [7:0] got_data [$];
  logic       got_isd  [$];

  task automatic model_reset();
    m_s1_v = 0; m_s1_code = '0;
    e_stb = 0; e_idle = 0; e_err = 0; e_isd = 0; e_sync = 0; e_data = '0;
    e_cnt16 = 0; e_cnt2 = 0; m_good = 0; m_bad = 0;
  endtask

  task automatic model_step();
    int k;
    if (e_stb || e_idle) begin
      m_bad = 0; m_good++;
      if (!e_sync && m_good >= SYNC_GOOD) e_sync = 1;
    end else if (e_err) begin
      m_good = 0; m_bad++;
      if (e_sync && m_bad >= LOSS_BAD) e_sync = 0;
    end
    e_stb = 0; e_idle = 0; e_err = 0;
    if (m_s1_v) begin
      k = int'(m_s1_code);
      if (!code_kind.exists(k)) begin
        e_err = 1; e_data = 8'h00; e_isd = 0;
      end else if (code_kind[k] == 3) e_idle = 1;
      else begin
        e_stb = 1; e_data = code_byte[k]; e_isd = (code_kind[k] == 1);
      end
    end
    if (clr) begin
      e_cnt16 = e_err ? 1 : 0;
      e_cnt2  = e_err ? 1 : 0;
    end else if (e_err) begin
      if (e_cnt16 < 65535) e_cnt16++;
      if (e_cnt2 < 3) e_cnt2++;
    end
    m_s1_v    = vld && en;
    m_s1_code = code;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_step();
    #1;
    check("stb",      a_stb,  e_stb);
    check("idle",     a_idle, e_idle);
    check("code_err", a_err,  e_err);
    check("data",     a_data, e_data);
    check("is_data",  a_isd,  e_isd);
    check("sync",     a_sync, e_sync);
    check("err_cnt",  a_cnt,  e_cnt16);
    check("w2_stb",   b_stb,  e_stb);
    check("w2_sync",  b_sync, e_sync);
    check("w2_cnt",   b_cnt,  e_cnt2);
    if (a_stb) begin
      stb_count++;
      got_data.push_back(a_data);
      got_isd.push_back(a_isd);
    end
    if (a_idle) idle_count++;
    if (a_err)  err_count++;
  end

  task automatic send(input logic [9:0] c, input bit v, input bit e, input bit cl);
    code = c; vld = v; en = e; clr = cl;
    @(posedge clk);
    #2;
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) send(10'h000, 0, 1, 0);
  endtask

  task automatic clear_log();
    got_data.delete();
    got_isd.delete();
    stb_count = 0; idle_count = 0; err_count = 0;
  endtask

  initial begin
    for (int b = 0; b < 256; b++) begin
      code_kind[int'(enc(8'(b), 1))] = 1;
      code_byte[int'(enc(8'(b), 1))] = 8'(b);
    end
    for (int d = 0; d < 64; d++) begin
      code_kind[int'(enc(8'(d), 0))] = 2;
      code_byte[int'(enc(8'(d), 0))] = 8'(d);
    end
    code_kind[int'(10'h29A)] = 3;

    check("model_size", code_kind.num(), 321);
    check("enc_00", enc(8'h00, 1), 10'h0E3);
    check("enc_A5", enc(8'hA5, 1), 10'h2B4);
    check("enc_FF", enc(8'hFF, 1), 10'h359);
    check("enc_c1B", enc(8'h1B, 0), 10'h1CE);
    check("enc_F6", enc(8'hF6, 1), 10'h1F0);

    repeat (3) @(posedge clk);
    #2;
    check("rst_cnt", a_cnt, 0);
    check("rst_sync", a_sync, 0);
    rst = 0;
    gap(2);

    clear_log();
    send(10'h0E3, 1, 1, 0);
    send(10'h2B4, 1, 1, 0);
    send(10'h359, 1, 1, 0);
    gap(3);
    check("dir_count", got_data.size(), 3);
    if (got_data.size() == 3) begin
      check("dir_d0", got_data[0], 8'h00);
      check("dir_d1", got_data[1], 8'hA5);
      check("dir_d2", got_data[2], 8'hFF);
      check("dir_isd", {got_isd[0], got_isd[1], got_isd[2]}, 3'b111);
    end
    check("sync_after3", a_sync, 0);

    clear_log();
    send(10'h1CE, 1, 1, 0);
    gap(3);
    check("ctrl_data", a_data, 8'h1B);
    check("ctrl_isd", a_isd, 0);
    check("sync_after4", a_sync, 1);

    clear_log();
    send(10'h29A, 1, 1, 0);
    gap(3);
    check("idle_pulses", idle_count, 1);
    check("idle_nostb", stb_count, 0);
    send(10'h1F0, 1, 1, 0);
    gap(3);
    check("f6_data", a_data, 8'hF6);

    rst = 1;
    gap(1);
    rst = 0;
    clear_log();
    send(10'h3FF, 1, 1, 0);
    send(10'h29C, 1, 1, 0);
    gap(3);
    check("err_pulses", err_count, 2);
    check("err_cnt2", a_cnt, 2);
    check("err_data", a_data, 8'h00);

    for (int i = 0; i < 4; i++) send(10'h0E3, 1, 1, 0);
    gap(3);
    check("resync", a_sync, 1);
    send(10'h3FF, 1, 1, 0);
    send(10'h3FF, 1, 1, 0);
    send(10'h0E3, 1, 1, 0);
    send(10'h3FF, 1, 1, 0);
    send(10'h3FF, 1, 1, 0);
    gap(3);
    check("hold_sync", a_sync, 1);
    send(10'h3FF, 1, 1, 0);
    gap(3);
    check("lost_sync", a_sync, 0);
    check("cnt16_7", a_cnt, 7);
    check("cnt2_sat", b_cnt, 3);
    send(10'h3FF, 1, 1, 0);
    send(10'h000, 0, 1, 1);
    gap(2);
    check("clr_err_cnt", a_cnt, 1);
    check("clr_err_w2", b_cnt, 1);
    send(10'h000, 0, 1, 1);
    gap(1);
    check("clr_cnt", a_cnt, 0);

    clear_log();
    send(10'h0E3, 1, 0, 0);
    send(10'h2B4, 1, 1, 0);
    send(10'h359, 1, 0, 0);
    gap(3);
    check("en_count", got_data.size(), 1);
    if (got_data.size() == 1) check("en_data", got_data[0], 8'hA5);

    clear_log();
    for (int b = 0; b < 256; b++) send(enc(8'(b), 1), 1, 1, 0);
    for (int d = 0; d < 64; d++) send(enc(8'(d), 0), 1, 1, 0);
    send(10'h29A, 1, 1, 0);
    gap(3);
    check("exh_stb", stb_count, 320);
    check("exh_idle", idle_count, 1);
    check("exh_err", err_count, 0);
    check("exh_sync", a_sync, 1);

    send(10'h0E3, 1, 1, 0);
    send(10'h2B4, 1, 1, 0);
    send(10'h359, 1, 1, 0);
    code = 10'h0E3;
    #3;
    rst = 1;
    #1;
    check("mid_rst_stb", a_stb, 0);
    check("mid_rst_data", a_data, 0);
    check("mid_rst_sync", a_sync, 0);
    check("mid_rst_cnt", a_cnt, 0);
    @(posedge clk);
    #2;
    rst = 0;
    clear_log();
    gap(4);
    check("post_rst_stb", stb_count, 0);
    check("post_rst_err", err_count, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
